// File: rtl/mem_burst_ctrl_fsm.sv
// Memory burst controller: accepts a read/write request in IDLE, issues N beats
// (single or BURST_LEN) with registered oe/we/addr_ofs/done/busy, then one RECOV cycle.
module mem_burst_ctrl_fsm #(
    parameter int BURST_LEN = 4,
    parameter bit WR_BURST  = 1'b1,
    localparam int CNT_W    = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem,
    input  logic             rw,
    input  logic             burst,
    output logic             oe,
    output logic             we,
    output logic [CNT_W-1:0] addr_ofs,
    output logic             done,
    output logic             busy,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        WRITE = 4'b0100,
        RECOV = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(BURST_LEN - 1);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] last_n;
    logic [CNT_W-1:0] cnt_n;
    logic             beat_n;

    assign state_dbg = state_q;

    // addr_ofs doubles as the beat counter; last_q holds N-1 for the active transaction.
    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        last_n  = last_q;
        case (state_q)
            IDLE: begin
                if (mem) begin
                    state_n = rw ? READ : WRITE;
                    last_n  = (burst && (rw || WR_BURST)) ? LAST_BURST : '0;
                end
            end
            READ, WRITE: begin
                if (addr_ofs == last_q) begin
                    state_n = RECOV;
                end else begin
                    state_n = state_q;
                    cnt_n   = addr_ofs + CNT_W'(1);
                end
            end
            RECOV: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                last_n  = '0;
            end
        endcase
        beat_n = (state_n == READ) || (state_n == WRITE);
    end

    // Outputs are loaded from the look-ahead decode so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            oe       <= 1'b0;
            we       <= 1'b0;
            addr_ofs <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            last_q   <= last_n;
            oe       <= (state_n == READ);
            we       <= (state_n == WRITE);
            addr_ofs <= cnt_n;
            done     <= beat_n && (cnt_n == last_n);
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl_fsm.sv
// Bench for mem_burst_ctrl_fsm: vector table, corner-case sequences and random
// traffic checked against a transaction-schedule model (BURST_LEN=4, WR_BURST=1 and 0).
module tb_mem_burst_ctrl_fsm;

    localparam int BL    = 4;
    localparam int CW    = 2;
    localparam int OBS_W = 4 + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem = 1'b0;
    logic          rw = 1'b0;
    logic          burst = 1'b0;
    logic          oe0, we0, done0, busy0;
    logic          oe1, we1, done1, busy1;
    logic [CW-1:0] ofs0, ofs1;
    logic [3:0]    st0, st1;

    int checks = 0;
    int errors = 0;

    // Each queue entry is the expected {oe, we, addr_ofs, done, busy} for one cycle.
    logic [OBS_W-1:0] exp_q0[$];
    logic [OBS_W-1:0] exp_q1[$];
    logic [OBS_W-1:0] exp0, exp1;

    mem_burst_ctrl_fsm #(.BURST_LEN(BL), .WR_BURST(1'b1)) dut (
        .clk(clk), .reset(reset), .mem(mem), .rw(rw), .burst(burst),
        .oe(oe0), .we(we0), .addr_ofs(ofs0), .done(done0), .busy(busy0), .state_dbg(st0)
    );

    mem_burst_ctrl_fsm #(.BURST_LEN(BL), .WR_BURST(1'b0)) dut_nw (
        .clk(clk), .reset(reset), .mem(mem), .rw(rw), .burst(burst),
        .oe(oe1), .we(we1), .addr_ofs(ofs1), .done(done1), .busy(busy1), .state_dbg(st1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, m, r, b;
        logic          oe, we;
        logic [CW-1:0] ofs;
        logic          done, busy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input int which, input int n, input logic is_rd);
        logic [OBS_W-1:0] r;
        for (int i = 0; i < n; i++) begin
            r = {is_rd, ~is_rd, CW'(i), (i == n - 1), 1'b1};
            if (which == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
        end
        r = {1'b0, 1'b0, {CW{1'b0}}, 1'b0, 1'b1};
        if (which == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
        r = '0;
        if (which == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
    endtask

    // Schedule model: an empty queue means the controller is idle and may take a request.
    task automatic model_edge();
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (exp_q0.size() == 0 && mem) push_txn(0, burst ? BL : 1, rw);
            if (exp_q1.size() == 0 && mem) push_txn(1, (burst && rw) ? BL : 1, rw);
        end
        exp0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
        exp1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
    endtask

    task automatic step(input logic r, input logic m, input logic w, input logic b);
        reset = r; mem = m; rw = w; burst = b;
        @(posedge clk);
        model_edge();
        #1;
        check("obs_wrburst1", 32'({oe0, we0, ofs0, done0, busy0}), 32'(exp0));
        check("obs_wrburst0", 32'({oe1, we1, ofs1, done1, busy1}), 32'(exp1));
    endtask

    int           we_cnt0, we_cnt1;
    logic         done_seen;
    logic         prev_oe;
    int           rise_at[$];

    initial begin
        //            rst m  r  b   oe we ofs done busy
        vecs[0]  = '{1, 1, 1, 1,  0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 1,  1, 0, 0, 0, 1};
        vecs[2]  = '{0, 0, 1, 1,  1, 0, 1, 0, 1};
        vecs[3]  = '{0, 1, 0, 0,  1, 0, 2, 0, 1};
        vecs[4]  = '{0, 1, 0, 0,  1, 0, 3, 1, 1};
        vecs[5]  = '{0, 1, 0, 0,  0, 0, 0, 0, 1};
        vecs[6]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0,  0, 1, 0, 1, 1};
        vecs[8]  = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].m, vecs[i].r, vecs[i].b);
            check($sformatf("vec%0d_oe", i), 32'(oe0), 32'(vecs[i].oe));
            check($sformatf("vec%0d_we", i), 32'(we0), 32'(vecs[i].we));
            check($sformatf("vec%0d_ofs", i), 32'(ofs0), 32'(vecs[i].ofs));
            check($sformatf("vec%0d_done", i), 32'(done0), 32'(vecs[i].done));
            check($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].busy));
        end

        // Write burst request: full burst when enabled, single beat when disabled.
        we_cnt0 = 0;
        we_cnt1 = 0;
        step(0, 1, 0, 1);
        we_cnt0 += int'(we0);
        we_cnt1 += int'(we1);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0);
            we_cnt0 += int'(we0);
            we_cnt1 += int'(we1);
        end
        check("wr_burst_beats", 32'(we_cnt0), 32'(BL));
        check("wr_single_beats", 32'(we_cnt1), 32'(1));

        // Reset during the third beat of a read burst.
        done_seen = 1'b0;
        step(0, 1, 1, 1);
        done_seen |= done0;
        step(0, 0, 0, 0);
        done_seen |= done0;
        step(0, 0, 0, 0);
        done_seen |= done0;
        check("abort_pre_ofs", 32'(ofs0), 32'(2));
        step(1, 0, 0, 0);
        done_seen |= done0;
        check("abort_oe", 32'(oe0), 32'(0));
        check("abort_busy", 32'(busy0), 32'(0));
        check("abort_ofs", 32'(ofs0), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            done_seen |= done0;
        end
        check("abort_no_done", 32'(done_seen), 32'(0));

        // Reads held back-to-back: first beats should be N+2 cycles apart.
        prev_oe = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 1);
            if (oe0 && !prev_oe) rise_at.push_back(i);
            prev_oe = oe0;
        end
        check("b2b_rises", 32'(rise_at.size()), 32'(4));
        if (rise_at.size() > 0) check("b2b_first", 32'(rise_at[0]), 32'(0));
        for (int i = 1; i < rise_at.size(); i++)
            check("b2b_spacing", 32'(rise_at[i] - rise_at[i-1]), 32'(BL + 2));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        // Random traffic with occasional resets and mid-transaction input churn.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("onehot_state", 32'($onehot(st0)), 32'(1));
            check("oe_we_excl", 32'(oe0 & we0), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
